// File: rtl/ts_tracklet_unpacker_pkg.sv
// Tracklet word layout shared by the tracklet FIFO read side, plus unpacker constants.
// The field macros mirror the project constants include; TS_UNPACK_BUF_DEPTH lives alongside them.
`ifndef TS_TRACKLET_CONSTANTS_SVH
`define TS_TRACKLET_CONSTANTS_SVH
`define STUB_X_IDX_BITS            5
`define STUB_X_PHY_BITS            8
`define STUB_Z_IDX_BITS            5
`define STUB_Z_PHY_BITS            8
`define CROSSING_NUMBER_BITS       4
`define STRUCT_TRACKLET_DATA_BITS  56
`define TRACKLET_IN_X_IDX_LSB      0
`define TRACKLET_IN_X_IDX_MSB      4
`define TRACKLET_IN_X_PHY_LSB      5
`define TRACKLET_IN_X_PHY_MSB      12
`define TRACKLET_IN_Z_IDX_LSB      13
`define TRACKLET_IN_Z_IDX_MSB      17
`define TRACKLET_IN_Z_PHY_LSB      18
`define TRACKLET_IN_Z_PHY_MSB      25
`define TRACKLET_OUT_X_IDX_LSB     26
`define TRACKLET_OUT_X_IDX_MSB     30
`define TRACKLET_OUT_X_PHY_LSB     31
`define TRACKLET_OUT_X_PHY_MSB     38
`define TRACKLET_OUT_Z_IDX_LSB     39
`define TRACKLET_OUT_Z_IDX_MSB     43
`define TRACKLET_OUT_Z_PHY_LSB     44
`define TRACKLET_OUT_Z_PHY_MSB     51
`define TRACKLET_CROSSING_LSB      52
`define TRACKLET_CROSSING_MSB      55
`define TS_UNPACK_BUF_DEPTH        2
`endif

package ts_tracklet_unpacker_pkg;

   localparam int TRK_W  = `STRUCT_TRACKLET_DATA_BITS;
   localparam int XI_W   = `STUB_X_IDX_BITS;
   localparam int XP_W   = `STUB_X_PHY_BITS;
   localparam int ZI_W   = `STUB_Z_IDX_BITS;
   localparam int ZP_W   = `STUB_Z_PHY_BITS;
   localparam int XING_W = `CROSSING_NUMBER_BITS;

   localparam int IN_X_IDX_LSB  = `TRACKLET_IN_X_IDX_LSB;
   localparam int IN_X_IDX_MSB  = `TRACKLET_IN_X_IDX_MSB;
   localparam int IN_X_PHY_LSB  = `TRACKLET_IN_X_PHY_LSB;
   localparam int IN_X_PHY_MSB  = `TRACKLET_IN_X_PHY_MSB;
   localparam int IN_Z_IDX_LSB  = `TRACKLET_IN_Z_IDX_LSB;
   localparam int IN_Z_IDX_MSB  = `TRACKLET_IN_Z_IDX_MSB;
   localparam int IN_Z_PHY_LSB  = `TRACKLET_IN_Z_PHY_LSB;
   localparam int IN_Z_PHY_MSB  = `TRACKLET_IN_Z_PHY_MSB;
   localparam int OUT_X_IDX_LSB = `TRACKLET_OUT_X_IDX_LSB;
   localparam int OUT_X_IDX_MSB = `TRACKLET_OUT_X_IDX_MSB;
   localparam int OUT_X_PHY_LSB = `TRACKLET_OUT_X_PHY_LSB;
   localparam int OUT_X_PHY_MSB = `TRACKLET_OUT_X_PHY_MSB;
   localparam int OUT_Z_IDX_LSB = `TRACKLET_OUT_Z_IDX_LSB;
   localparam int OUT_Z_IDX_MSB = `TRACKLET_OUT_Z_IDX_MSB;
   localparam int OUT_Z_PHY_LSB = `TRACKLET_OUT_Z_PHY_LSB;
   localparam int OUT_Z_PHY_MSB = `TRACKLET_OUT_Z_PHY_MSB;
   localparam int XING_LSB      = `TRACKLET_CROSSING_LSB;
   localparam int XING_MSB      = `TRACKLET_CROSSING_MSB;

   localparam int BUF_DEPTH_BASE = `TS_UNPACK_BUF_DEPTH;

   // The first-of-crossing flag travels with the word through the output buffer.
   typedef struct packed {
      logic             first;
      logic [TRK_W-1:0] word;
   } skid_entry_t;

   function automatic logic [XING_W-1:0] word_xing(input logic [TRK_W-1:0] w);
      return w[XING_MSB:XING_LSB];
   endfunction

endpackage

// File: rtl/ts_tracklet_skid_buf.sv
// Small synchronous circular buffer with occupancy; head entry is visible combinationally.
// A pop and a push in the same cycle on a full buffer are both honoured.
module ts_tracklet_skid_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   localparam int OCC_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head_data,
   output logic             empty,
   output logic [OCC_W-1:0] occupancy
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             do_pop, do_push;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop   = pop && (occ_q != '0);
      do_push  = push && ((occ_q != OCC_W'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = (occ_q == '0);
   assign occupancy = occ_q;

endmodule

// File: rtl/ts_tracklet_unpacker.sv
// Tracklet FIFO read side: pops packed words, buffers them and splits them into stub fields.
// Optional per-crossing accept counter enabled by defining TS_TRACKLET_CNT_EN.
module ts_tracklet_unpacker
   import ts_tracklet_unpacker_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int CNT_BITS   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [TRK_W-1:0]         fifo_dout,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic                     out_first,
   output logic signed [XI_W-1:0]   in_stub_x_idx,
   output logic signed [XP_W-1:0]   in_stub_x_phy,
   output logic signed [ZI_W-1:0]   in_stub_z_idx,
   output logic signed [ZP_W-1:0]   in_stub_z_phy,
   output logic signed [XI_W-1:0]   out_stub_x_idx,
   output logic signed [XP_W-1:0]   out_stub_x_phy,
   output logic signed [ZI_W-1:0]   out_stub_z_idx,
   output logic signed [ZP_W-1:0]   out_stub_z_phy,
   output logic [XING_W-1:0]        crossing_num
`ifdef TS_TRACKLET_CNT_EN
   ,
   output logic [CNT_BITS-1:0]      trk_count
`endif
);

   localparam int BUF_DEPTH = BUF_DEPTH_BASE + RD_LATENCY - 1;
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
   localparam int ENT_W     = $bits(skid_entry_t);

   if (RD_LATENCY < 1 || RD_LATENCY > 2 || CNT_BITS < 1) begin : g_param_check
      $error("ts_tracklet_unpacker: RD_LATENCY must be 1 or 2 and CNT_BITS at least 1");
   end

   logic [RD_LATENCY-1:0] inflight_q, inflight_d;
   logic [XING_W-1:0]     last_xing_q, last_xing_d;
   logic                  last_xing_valid_q, last_xing_valid_d;
   logic                  run_q, run_d;

   logic [OCC_W-1:0]      occ;
   logic [OCC_W:0]        pending;
   logic                  buf_empty;
   logic                  landing, accept, buf_push, buf_pop;
   skid_entry_t           land_ent, head_ent, shown_ent;
   logic [ENT_W-1:0]      head_bits;

   ts_tracklet_skid_buf #(
      .W     (ENT_W),
      .DEPTH (BUF_DEPTH)
   ) u_skid_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (buf_push),
      .push_data (land_ent),
      .pop       (buf_pop),
      .head_data (head_bits),
      .empty     (buf_empty),
      .occupancy (occ)
   );

   assign head_ent = skid_entry_t'(head_bits);

   // A word landing on an empty buffer is presented straight from fifo_dout, so the
   // first word needs no extra register stage; it is only stored if not accepted.
   always_comb begin
      run_d          = 1'b1;
      landing        = inflight_q[RD_LATENCY-1];
      land_ent.first = !last_xing_valid_q || (word_xing(fifo_dout) != last_xing_q);
      land_ent.word  = fifo_dout;
      out_valid      = !buf_empty || landing;
      accept         = out_valid && out_ready;
      buf_pop        = accept && !buf_empty;
      buf_push       = landing && !(buf_empty && out_ready);

      pending = {1'b0, occ};
      for (int i = 0; i < RD_LATENCY; i++) begin
         pending = pending + (OCC_W + 1)'(inflight_q[i]);
      end
      fifo_rd_en = run_q && !fifo_empty && (pending < (OCC_W + 1)'(BUF_DEPTH));
      inflight_d = RD_LATENCY'({inflight_q, fifo_rd_en});

      last_xing_d       = last_xing_q;
      last_xing_valid_d = last_xing_valid_q;
      if (landing) begin
         last_xing_d       = word_xing(fifo_dout);
         last_xing_valid_d = 1'b1;
      end

      shown_ent = '0;
      if (!buf_empty) begin
         shown_ent = head_ent;
      end else if (landing) begin
         shown_ent = land_ent;
      end
   end

   // run_q holds off reads for the first cycle after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_q        <= '0;
         last_xing_q       <= '0;
         last_xing_valid_q <= 1'b0;
         run_q             <= 1'b0;
      end else begin
         inflight_q        <= inflight_d;
         last_xing_q       <= last_xing_d;
         last_xing_valid_q <= last_xing_valid_d;
         run_q             <= run_d;
      end
   end

   assign out_first      = shown_ent.first;
   assign in_stub_x_idx  = $signed(shown_ent.word[IN_X_IDX_MSB:IN_X_IDX_LSB]);
   assign in_stub_x_phy  = $signed(shown_ent.word[IN_X_PHY_MSB:IN_X_PHY_LSB]);
   assign in_stub_z_idx  = $signed(shown_ent.word[IN_Z_IDX_MSB:IN_Z_IDX_LSB]);
   assign in_stub_z_phy  = $signed(shown_ent.word[IN_Z_PHY_MSB:IN_Z_PHY_LSB]);
   assign out_stub_x_idx = $signed(shown_ent.word[OUT_X_IDX_MSB:OUT_X_IDX_LSB]);
   assign out_stub_x_phy = $signed(shown_ent.word[OUT_X_PHY_MSB:OUT_X_PHY_LSB]);
   assign out_stub_z_idx = $signed(shown_ent.word[OUT_Z_IDX_MSB:OUT_Z_IDX_LSB]);
   assign out_stub_z_phy = $signed(shown_ent.word[OUT_Z_PHY_MSB:OUT_Z_PHY_LSB]);
   assign crossing_num   = shown_ent.word[XING_MSB:XING_LSB];

`ifdef TS_TRACKLET_CNT_EN
   logic [CNT_BITS-1:0] trk_count_q, trk_count_d;

   always_comb begin
      trk_count_d = trk_count_q;
      if (accept) begin
         if (out_first) begin
            trk_count_d = CNT_BITS'(1);
         end else if (trk_count_q != '1) begin
            trk_count_d = trk_count_q + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trk_count_q <= '0;
      end else begin
         trk_count_q <= trk_count_d;
      end
   end

   assign trk_count = trk_count_q;
`endif

endmodule

// File: tb/tb_ts_tracklet_unpacker.sv
// Directed bench for ts_tracklet_unpacker with a behavioural latency-1 tracklet FIFO core.
// Honours TS_TRACKLET_CNT_EN when defined.
module tb_ts_tracklet_unpacker;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [55:0]        fifo_dout = '0;
   logic               fifo_empty;
   logic               fifo_rd_en;
   logic               out_ready = 1'b0;
   logic               out_valid;
   logic               out_first;
   logic signed [4:0]  in_stub_x_idx, in_stub_z_idx, out_stub_x_idx, out_stub_z_idx;
   logic signed [7:0]  in_stub_x_phy, in_stub_z_phy, out_stub_x_phy, out_stub_z_phy;
   logic [3:0]         crossing_num;
`ifdef TS_TRACKLET_CNT_EN
   logic [7:0]         trk_count;
`endif

   always #5 clk = ~clk;

   ts_tracklet_unpacker #(
      .RD_LATENCY (1),
      .CNT_BITS   (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fifo_dout      (fifo_dout),
      .fifo_empty     (fifo_empty),
      .fifo_rd_en     (fifo_rd_en),
      .out_ready      (out_ready),
      .out_valid      (out_valid),
      .out_first      (out_first),
      .in_stub_x_idx  (in_stub_x_idx),
      .in_stub_x_phy  (in_stub_x_phy),
      .in_stub_z_idx  (in_stub_z_idx),
      .in_stub_z_phy  (in_stub_z_phy),
      .out_stub_x_idx (out_stub_x_idx),
      .out_stub_x_phy (out_stub_x_phy),
      .out_stub_z_idx (out_stub_z_idx),
      .out_stub_z_phy (out_stub_z_phy),
      .crossing_num   (crossing_num)
`ifdef TS_TRACKLET_CNT_EN
      ,
      .trk_count      (trk_count)
`endif
   );

   // Behavioural FIFO core: word appears on fifo_dout one cycle after rd_en.
   logic [55:0] mem [0:127];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Accept monitor.
   int                cyc = 0;
   int                acc_n = 0;
   int                bad_rd = 0;
   logic              prev_acc = 1'b0;
   int                acc_cyc   [0:127];
   logic signed [7:0] acc_xphy  [0:127];
   logic              acc_first [0:127];
   logic [7:0]        acc_cnt   [0:127];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fifo_rd_en && fifo_empty) bad_rd <= bad_rd + 1;
`ifdef TS_TRACKLET_CNT_EN
      if (prev_acc) acc_cnt[acc_n-1] <= trk_count;
`endif
      prev_acc <= reset && out_valid && out_ready;
      if (reset && out_valid && out_ready) begin
         acc_cyc[acc_n]   <= cyc;
         acc_xphy[acc_n]  <= in_stub_x_phy;
         acc_first[acc_n] <= out_first;
         acc_n            <= acc_n + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [55:0] pack(input int xing, input int ixi, input int ixp, input int izi,
                                        input int izp, input int oxi, input int oxp, input int ozi,
                                        input int ozp);
      return {4'(xing), 8'(ozp), 5'(ozi), 8'(oxp), 5'(oxi), 8'(izp), 5'(izi), 8'(ixp), 5'(ixi)};
   endfunction

   task automatic push(input logic [55:0] w);
      mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   int xing_tab  [9] = '{3, 3, 4, 4, 4, 0, 15, 15, 0};
   int first_tab [9] = '{1, 0, 1, 0, 0, 1, 1, 0, 1};
   int cnt_tab   [9] = '{1, 2, 1, 2, 3, 1, 1, 2, 1};
   int base;
   int rdc, bad, vc;

   initial begin
      // Reset held with data waiting in the FIFO core.
      push(pack(5, -3, 11, 2, -20, 7, -100, -9, 17));
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_first", out_first, 0);
      chk("rst_in_x_idx", in_stub_x_idx, 0);
      chk("rst_out_z_phy", out_stub_z_phy, 0);
      chk("rst_xing", crossing_num, 0);

      @(posedge clk); #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_rd_en", fifo_rd_en, 1);
      chk("release_valid_early", out_valid, 0);
      @(negedge clk);
      chk("single_valid", out_valid, 1);
      chk("single_in_x_idx", in_stub_x_idx, -3);
      chk("single_in_z_phy", in_stub_z_phy, -20);
      chk("single_out_x_phy", out_stub_x_phy, -100);
      chk("single_out_z_phy", out_stub_z_phy, 17);
      chk("single_xing", crossing_num, 5);
      chk("single_first", out_first, 1);
      chk("single_rd_en_empty", fifo_rd_en, 0);
      repeat (3) @(negedge clk);

      // Gapless stream of 8 words.
      @(posedge clk); #1;
      base = acc_n;
      for (int i = 0; i < 8; i++) push(pack(7, 1, i * 10, 0, 0, 0, 0, 0, i + 1));
      repeat (14) @(negedge clk);
      chk("stream_count", acc_n - base, 8);
      chk("stream_gapless", acc_cyc[base+7] - acc_cyc[base], 7);
      for (int i = 0; i < 8; i++) chk($sformatf("stream_order_%0d", i), acc_xphy[base+i], i * 10);
      chk("stream_first0", acc_first[base], 1);
      chk("stream_first1", acc_first[base+1], 0);

      // Backpressure for 10 cycles.
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(pack(8, 0, 20 + i, 0, 0, 0, 0, 0, 0));
      rdc = 0; bad = 0; vc = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_rd_en) rdc++;
         if (out_valid) begin
            vc++;
            if (in_stub_x_phy != 20 || crossing_num != 8) bad++;
         end
      end
      chk("bp_rd_en_count", rdc, 2);
      chk("bp_hold_stable", bad, 0);
      chk("bp_valid_cycles", vc, 9);
      @(posedge clk); #1;
      base      = acc_n;
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("bp_count", acc_n - base, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("bp_order_%0d", i), acc_xphy[base+i], 20 + i);

      // Crossing changes including wraps to 0.
      @(posedge clk); #1;
      base = acc_n;
      for (int i = 0; i < 9; i++) push(pack(xing_tab[i], 0, 40 + i, 0, 0, 0, 0, 0, 0));
      repeat (16) @(negedge clk);
      chk("xing_count", acc_n - base, 9);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("xing_first_%0d", i), acc_first[base+i], first_tab[i]);
`ifdef TS_TRACKLET_CNT_EN
         chk($sformatf("trk_count_%0d", i), acc_cnt[base+i], cnt_tab[i]);
`endif
      end

      // Asynchronous reset with two words held in the unpacker.
      @(posedge clk); #1;
      out_ready = 1'b0;
      push(pack(6, 0, 77, 0, 0, 0, 0, 0, 0));
      push(pack(6, 0, 78, 0, 0, 0, 0, 0, 0));
      repeat (4) @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_rd_en", fifo_rd_en, 0);
      chk("async_rst_x_phy", in_stub_x_phy, 0);
      chk("async_rst_xing", crossing_num, 0);
      @(posedge clk); #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      base      = acc_n;
      repeat (6) @(negedge clk);
      chk("post_rst_no_stale", acc_n - base, 0);

      // Same crossing as before reset is still first after reset.
      @(posedge clk); #1;
      push(pack(6, 0, 99, 0, 0, 0, 0, 0, 0));
      repeat (5) @(negedge clk);
      chk("post_rst_count", acc_n - base, 1);
      chk("post_rst_x_phy", acc_xphy[base], 99);
      chk("post_rst_first", acc_first[base], 1);

      chk("rd_en_while_empty", bad_rd, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
